// File: rtl/progmem_fetcher_if.sv
// Bus bundle for progmem_fetcher: control, Avalon-MM read master and instruction stream.
// The master modport is the fetcher side; the slave modport is its environment.
interface progmem_fetcher_if #(
  parameter int unsigned ADDR_W = 12
) ();
  logic              start_valid;
  logic [ADDR_W-1:0] start_addr;
  logic              stop;

  logic [ADDR_W-1:0] mst_address;
  logic              mst_read;
  logic [31:0]       mst_readdata;
  logic [1:0]        mst_response;
  logic              mst_waitrequest;

  logic              instr_valid;
  logic [31:0]       instr_data;
  logic [ADDR_W-1:0] instr_addr;
  logic              instr_ready;

  logic              fetch_err;
  logic              busy;

  modport master (
    input  start_valid, start_addr, stop,
    output mst_address, mst_read,
    input  mst_readdata, mst_response, mst_waitrequest,
    output instr_valid, instr_data, instr_addr,
    input  instr_ready,
    output fetch_err, busy
  );

  modport slave (
    output start_valid, start_addr, stop,
    input  mst_address, mst_read,
    output mst_readdata, mst_response, mst_waitrequest,
    input  instr_valid, instr_data, instr_addr,
    output instr_ready,
    input  fetch_err, busy
  );
endinterface

// File: rtl/progmem_fetcher.sv
// Program-memory read master: one outstanding Avalon-MM read at a time, feeding a small
// prefetch FIFO that presents {word, address} pairs to the consumer over valid/ready.
module progmem_fetcher #(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  progmem_fetcher_if.master bus
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StError} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mst_address_q, mst_address_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic              mst_read_q, mst_read_d;
  logic              fetch_err_q, fetch_err_d;
  logic [31:0]       data_mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] addr_mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;

  logic complete, resp_ok, in_flight;
  logic push, pop, issue, busy, instr_valid;

  // A read still pending after this edge keeps mst_read/mst_address frozen.
  assign complete  = mst_read_q & ~bus.mst_waitrequest;
  assign resp_ok   = (bus.mst_response == 2'b00);
  assign in_flight = mst_read_q & ~complete;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (bus.start_valid) begin
      // A read completing in the same cycle as the restart is simply dropped.
      state_d = in_flight ? StDrain : StFetch;
    end else begin
      case (state_q)
        StFetch: if (complete && !resp_ok) state_d = StError;
        StDrain: if (complete) state_d = StFetch;
        default: state_d = state_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy        = (state_q != StIdle) | mst_read_q;
    instr_valid = (count_q != '0);
    push        = (state_q == StFetch) & complete & resp_ok & ~bus.start_valid;
    pop         = instr_valid & bus.instr_ready & ~bus.start_valid;
  end

  // ---------------------------------------------------------------------------
  // Datapath next state
  // ---------------------------------------------------------------------------
  always_comb begin
    fetch_addr_d = fetch_addr_q;
    if (bus.start_valid) begin
      fetch_addr_d = bus.start_addr;
    end else if (push) begin
      fetch_addr_d = mst_address_q + ADDR_W'(1);
    end

    if (bus.start_valid) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      count_d  = count_q + CntW'(push) - CntW'(pop);
      wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    end

    // After a completion the outstanding count is zero, so post-update occupancy decides.
    issue = (state_d == StFetch) & ~in_flight & ~bus.stop & (count_d < CntW'(FIFO_DEPTH));
    mst_read_d    = in_flight | issue;
    mst_address_d = issue ? fetch_addr_d : mst_address_q;

    fetch_err_d = fetch_err_q;
    if (bus.start_valid) begin
      fetch_err_d = 1'b0;
    end else if ((state_q == StFetch) && complete && !resp_ok) begin
      fetch_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mst_address_q <= '0;
      mst_read_q    <= 1'b0;
      fetch_addr_q  <= '0;
      fetch_err_q   <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      mst_address_q <= mst_address_d;
      mst_read_q    <= mst_read_d;
      fetch_addr_q  <= fetch_addr_d;
      fetch_err_q   <= fetch_err_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // Storage is cleared on reset so the head outputs read zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_mem_q[i] <= '0;
        addr_mem_q[i] <= '0;
      end
    end else if (push) begin
      data_mem_q[wr_ptr_q] <= bus.mst_readdata;
      addr_mem_q[wr_ptr_q] <= mst_address_q;
    end
  end

  assign bus.mst_address = mst_address_q;
  assign bus.mst_read    = mst_read_q;
  assign bus.instr_valid = instr_valid;
  assign bus.instr_data  = data_mem_q[rd_ptr_q];
  assign bus.instr_addr  = addr_mem_q[rd_ptr_q];
  assign bus.fetch_err   = fetch_err_q;
  assign bus.busy        = busy;

endmodule

// File: doc/progmem_fetcher.md
Name: progmem_fetcher

Overview:
- Avalon-MM style read master that streams 32-bit program words out of the program-memory slave into a small prefetch FIFO.
- Presents the words to a consumer (sequencer/CPU core) over a valid/ready interface.
- Sits between the command sequencer and the program ROM wrapper; it is the initiator end of the `ctrl_*` read interface.
- Supports restart at an arbitrary word address with flush, and halts on a slave error response.

Parameters:
- ADDR_W, 12: word-address width on the master port.
- FIFO_DEPTH, 4: prefetch FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start_valid  in  1  one-cycle pulse: flush and begin fetching at start_addr
- start_addr  in  ADDR_W  first word address of the new fetch stream
- stop  in  1  level: when high, no new reads are issued (an in-flight read still completes)
- mst_address  out  ADDR_W  read word address
- mst_read  out  1  read request
- mst_readdata  in  32  read data, valid when mst_read=1 and mst_waitrequest=0
- mst_response  in  2  00=OK, anything else=error; sampled with readdata
- mst_waitrequest  in  1  slave stall
- instr_valid  out  1  FIFO head valid
- instr_data  out  32  FIFO head word
- instr_addr  out  ADDR_W  word address of FIFO head
- instr_ready  in  1  consumer accepts head when instr_valid=1
- fetch_err  out  1  sticky error flag
- busy  out  1  state != IDLE or a read is outstanding

Behaviour:
- Reset values (async on rst high): mst_read=0, mst_address=0, instr_valid=0, instr_data=0, instr_addr=0, fetch_err=0, busy=0, FIFO empty, state=IDLE.
- States and transitions:
  - IDLE: waits for start_valid.
  - FETCH: streams words.
  - DRAIN: finishes a read made obsolete by a restart, then discards its data.
  - ERROR: halted; fetch_err=1.
  - start_valid is accepted in any state.
- Transfer rule: a read completes in the cycle where mst_read=1 and mst_waitrequest=0. mst_address and mst_read are held stable from assertion until completion; the read is never withdrawn early.
- Issue rule, in FETCH: mst_read is asserted when all of the following hold:
  - stop=0;
  - (FIFO occupancy + outstanding reads) < FIFO_DEPTH.
  - At most one read is outstanding.
  - A new read may start in the cycle after completion.
  - Against the program-memory slave (waitrequest low one cycle after read) this gives 1 word per 2 cycles.
- On completion with response=00:
  - push {readdata, address} into the FIFO;
  - next address = address+1, wrapping from 2^ADDR_W-1 to 0; wrap is not an error.
- On completion with response!=00:
  - data is not pushed;
  - state goes to ERROR and fetch_err is set;
  - the FIFO keeps its contents, which the consumer may still drain.
- Consumer side:
  - instr_valid = FIFO non-empty; instr_* reflect the FIFO head.
  - A pop happens on instr_valid & instr_ready.
  - A push and a pop in the same cycle are both honoured; occupancy is unchanged.
  - A full FIFO never receives a push, guaranteed by the issue rule.
- start_valid:
  - FIFO is flushed at that clock edge; instr_valid=0 the next cycle.
  - fetch_err is cleared.
  - Next address is loaded from start_addr.
  - With no read in flight: go to FETCH, and the first mst_read is asserted the next cycle.
  - With a read in flight: go to DRAIN, keep mst_read/mst_address stable until completion, drop the returned data and response, then go to FETCH.
  - start_valid during DRAIN reloads the pending address (the last one wins).
- A pop in the same cycle as start_valid is ignored; the flush wins.
- Latency from start_valid (no read in flight) to the first instr_valid, with a 1-cycle-waitrequest slave: 3 cycles.
- Reset mid-transfer drops mst_read immediately. The slave wrapper is reset by the same system reset, so this is legal.

Test Plan:
- Sequential fetch:
  - Stimulus: rst, then start_valid with start_addr=0x010; instr_ready=1; ROM word[n]=n*3.
  - Required: instr_data sequence 0x30,0x33,0x36… with instr_addr 0x010,0x011…; one word per 2 cycles; first instr_valid 3 cycles after start.
- Backpressure:
  - Stimulus: instr_ready=0 after start_valid at 0.
  - Required: exactly 4 reads are issued, then mst_read stays 0.
  - Then instr_ready=1: reads resume and there is no gap or duplicate in instr_addr.
- Wrap-around:
  - Stimulus: start_addr=0xFFE.
  - Required: instr_addr sequence 0xFFE,0xFFF,0x000,0x001; fetch_err stays 0.
- Restart mid-read:
  - Stimulus: pulse start_valid with start_addr=0x100 while mst_read=1 and waitrequest=1 at 0x005.
  - Required: mst_address stays 0x005 until completion; data for 0x005 is never presented; next read is to 0x100; FIFO is empty the cycle after the pulse.
- Error response:
  - Stimulus: slave returns response=2 on address 0x007.
  - Required: fetch_err=1, no further mst_read, words 0x000–0x006 still delivered.
  - A subsequent start_valid clears fetch_err and fetching restarts.
- Async reset:
  - Stimulus: assert rst with the FIFO holding 3 entries and a read outstanding.
  - Required: all outputs at their reset values immediately, without waiting for a clock edge.
